// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 8:1 mux scan controller.
package mux_scan_pkg;

  localparam int SEL_W  = 3;
  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    PUBLISH
  } state_t;

  // Channel index to select pins {b0,b1,b2}; b0 carries the index MSB.
  function automatic logic [SEL_W-1:0] sel_bits(input logic [SEL_W-1:0] k);
    return {k[2], k[1], k[0]};
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while run is high and wraps; tc flags the last count.
// Dropping run returns the count to 0 so every channel starts a fresh dwell.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan sequencer for the 8:1 data-select mux; packs one sampled bit per channel into a frame.
// Define MUX_SCAN_SYNC_EN to pass s_in through a 2-flop synchronizer (then DWELL must be >= 3).
module mux_scan_ctrl #(
  parameter int N_CH  = 7,
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            s_in,
  output logic            b0,
  output logic            b1,
  output logic            b2,
  output logic            busy,
  output logic [N_CH-1:0] frame_out,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic            changed
);
  import mux_scan_pkg::*;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
    $error("mux_scan_ctrl: N_CH must be in 1..8");
  end
  if ((2 ** CNT_W) < DWELL) begin : g_bad_cnt_w
    $error("mux_scan_ctrl: CNT_W too narrow for DWELL");
  end

  state_t            state;
  state_t            state_nxt;
  logic [SEL_W-1:0]  k;
  logic [SEL_W-1:0]  k_nxt;
  logic [N_CH-1:0]   shadow;
  logic [N_CH-1:0]   last_acc;
  logic              s_samp;
  logic              tc;
  logic              run;
  logic              sample;
  logic              load;
  logic              xfer;
  logic              can_load;
  logic              last_ch;

`ifdef MUX_SCAN_SYNC_EN
  logic [1:0] sync;

  if (DWELL < 3) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be >= 3 with the s_in synchronizer");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], s_in};
    end
  end

  assign s_samp = sync[1];
`else
  if (DWELL < 1) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be >= 1");
  end

  assign s_samp = s_in;
`endif

  mux_scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tc    (tc)
  );

  assign xfer     = frame_valid && frame_ready;
  assign can_load = !frame_valid || frame_ready;
  assign last_ch  = (k == LAST_CH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= mux_scan_pkg::IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      mux_scan_pkg::IDLE: begin
        if (en) state_nxt = mux_scan_pkg::DWELL;
      end
      mux_scan_pkg::DWELL: begin
        if (!en)                state_nxt = mux_scan_pkg::IDLE;
        else if (tc && last_ch) state_nxt = mux_scan_pkg::PUBLISH;
      end
      mux_scan_pkg::PUBLISH: begin
        if (can_load) state_nxt = en ? mux_scan_pkg::DWELL : mux_scan_pkg::IDLE;
      end
      default: state_nxt = mux_scan_pkg::IDLE;
    endcase
  end

  // Dropping en mid-scan abandons the partial frame; the shadow bits are simply overwritten later.
  always_comb begin
    busy   = 1'b0;
    run    = 1'b0;
    sample = 1'b0;
    load   = 1'b0;
    k_nxt  = k;
    case (state)
      mux_scan_pkg::IDLE: begin
        k_nxt = '0;
      end
      mux_scan_pkg::DWELL: begin
        busy = 1'b1;
        if (!en) begin
          k_nxt = '0;
        end else begin
          run = 1'b1;
          if (tc) begin
            sample = 1'b1;
            if (!last_ch) k_nxt = k + SEL_W'(1);
          end
        end
      end
      mux_scan_pkg::PUBLISH: begin
        busy = 1'b1;
        if (can_load) begin
          load  = 1'b1;
          k_nxt = '0;
        end
      end
      default: k_nxt = '0;
    endcase
  end

  // On a load that coincides with a transfer, the frame leaving now is the one to compare against.
  always_ff @(posedge clk) begin
    if (reset) begin
      k           <= '0;
      shadow      <= '0;
      last_acc    <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
    end else begin
      k <= k_nxt;
      if (sample) begin
        for (int i = 0; i < N_CH; i++) begin
          if (k == SEL_W'(i)) shadow[i] <= s_samp;
        end
      end
      if (xfer) last_acc <= frame_out;
      if (load) begin
        frame_out   <= shadow;
        frame_valid <= 1'b1;
        changed     <= (shadow != (xfer ? frame_out : last_acc));
      end else if (xfer) begin
        frame_valid <= 1'b0;
      end
    end
  end

  assign {b0, b1, b2} = sel_bits(k);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with an 8:1 mux model on s_in and a frame scoreboard.
module tb_mux_scan_ctrl;

  typedef struct packed {
    logic [6:0] f;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       s_in;
  logic       b0;
  logic       b1;
  logic       b2;
  logic       busy;
  logic [6:0] frame_out;
  logic       frame_valid;
  logic       frame_ready;
  logic       changed;
  logic [7:0] e_vec;
  logic [2:0] sel;

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign sel  = {b0, b1, b2};
  assign s_in = e_vec[sel];

  mux_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .s_in        (s_in),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .busy        (busy),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .changed     (changed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tk();
    @(negedge clk);
  endtask

  // Monitor samples late in the low phase, after the bench has driven frame_ready for the coming edge.
  always begin
    exp_t x;
    @(negedge clk);
    #3;
    if (!reset && frame_valid && frame_ready) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL sb_unexpected: got frame %0h, expected none", frame_out);
      end else begin
        x = sb.pop_front();
        chk("sb_frame", frame_out, x.f);
        chk("sb_changed", changed, x.c);
      end
    end
  end

  initial begin
    int   n;
    int   r1;
    int   r2;
    logic pv;
    logic stable;
    exp_t d;

    r1 = 0;
    r2 = 0;
    pv = 1'b0;
    reset = 1'b1;
    en = 1'b0;
    frame_ready = 1'b1;
    e_vec = 8'h53;
    sb.push_back({7'h53, 1'b1});
    sb.push_back({7'h53, 1'b0});

    tk(); tk(); tk();
    chk("init_sel", sel, 0);
    chk("init_busy", busy, 0);
    chk("init_valid", frame_valid, 0);
    chk("init_frame", frame_out, 0);
    chk("init_changed", changed, 0);

    // Free-running scan with ready held high.
    #1 reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tk();
      if (i <= 29) chk("sel_seq", sel, ((i - 1) / 4 > 6) ? 6 : (i - 1) / 4);
      if (i == 30) chk("sel_wrap", sel, 0);
      if (frame_valid && !pv) begin
        if (r1 == 0) r1 = i;
        else if (r2 == 0) r2 = i;
      end
      pv = frame_valid;
    end
    chk("first_latency", r1 - 1, 29);
    chk("frame_period", r2 - r1, 29);

    // Two-cycle reset in the middle of the third scan.
    #1 reset = 1'b1; frame_ready = 1'b0;
    tk(); tk();
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_frame", frame_out, 0);
    chk("rst_changed", changed, 0);
    #1 reset = 1'b0;
    sb.push_back({7'h53, 1'b1});
    sb.push_back({7'h2C, 1'b1});
    n = 0;
    do begin tk(); n++; end while (!frame_valid && n < 100);
    chk("valid_after_reset", frame_valid, 1);
    chk("latency_after_reset", n - 1, 29);

    // Backpressure: next frame completes and stalls in PUBLISH.
    #1 e_vec = 8'h2C;
    stable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tk();
      if (frame_out !== 7'h53 || frame_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    chk("bp_sel", sel, 6);
    chk("bp_busy", busy, 1);
    #1 frame_ready = 1'b1;
    tk();
    chk("bp_valid_held", frame_valid, 1);
    chk("bp_new_frame", frame_out, 7'h2C);
    tk();
    #1 frame_ready = 1'b0;

    // Leave a frame pending, then drop en during channel 3.
    sb.push_back({7'h2C, 1'b0});
    n = 0;
    do begin tk(); n++; end while (!frame_valid && n < 60);
    chk("pending_loaded", frame_valid, 1);
    n = 0;
    while (sel != 3'd3 && n < 40) begin tk(); n++; end
    chk("reach_ch3", sel, 3);
    #1 en = 1'b0;
    tk();
    chk("endrop_sel", sel, 0);
    chk("endrop_busy", busy, 0);
    chk("endrop_valid", frame_valid, 1);
    chk("endrop_frame", frame_out, 7'h2C);
    tk();
    #1 e_vec = 8'h7F; en = 1'b1;

    // e2 drops one cycle before its sample point, e4 drops at the start of its dwell.
`ifdef MUX_SCAN_SYNC_EN
    d = {7'h6F, 1'b1};
`else
    d = {7'h6B, 1'b1};
`endif
    sb.push_back(d);
    for (int i = 1; i <= 35; i++) begin
      tk();
      if (i == 1) chk("restart_ch0", sel, 0);
      if (i == 12) #1 e_vec[2] = 1'b0;
      if (i == 17) #1 e_vec[4] = 1'b0;
    end
    chk("stall_sel", sel, 6);
    chk("stall_frame", frame_out, 7'h2C);
    #1 frame_ready = 1'b1;
    tk();
    tk();
    #1 en = 1'b0;
    tk(); tk(); tk();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
